decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL expose these ports:
- clk_i  input  1  clock
- rst_i  input  1  sync active-high reset
- inst_i  input  32  fetched instruction
- pc_i  input  64  PC of inst_i
- valid_i  input  1  upstream offers inst_i/pc_i
- ready_o  output  1  stage can accept this cycle
- flush_i  input  1  discard held and incoming instruction
- valid_o  output  1  registered decode result valid
- ready_i  input  1  downstream accepts result
- pc_o  output  64  registered PC
- imm_o  output  64  selected sign-extended immediate
- imm_type_o  output  3  0=NONE 1=I 2=S 3=B 4=U 5=J
- rs1_o / rs2_o / rd_o  output  5 each  inst[19:15] / inst[24:20] / inst[11:7]
- use_imm_o  output  1  operand-B select: immediate (1) / rs2 (0)
- illegal_o  output  1  unrecognised encoding

Function
REQ-003 SHALL classify by inst_i[6:0] (RV64I):
- U-type: 0110111 LUI, 0010111 AUIPC
- J-type: 1101111 JAL
- I-type: 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0011011 OP-IMM-32, 0001111 MISC-MEM, 1110011 SYSTEM
- B-type: 1100011 BRANCH
- S-type: 0100011 STORE
- NONE: 0110011 OP, 0111011 OP-32
REQ-004 Any other opcode SHALL give illegal_o=1, imm_type_o=NONE, imm_o=0; inst_i[1:0]!=2'b11 counts as another opcode.
REQ-005 Immediates SHALL follow RV64I, sign-extended from inst[31] to 64 bits:
- I: inst[31:20]
- S: {inst[31:25], inst[11:7]}
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
- U: {inst[31:12], 12'b0}
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
REQ-006 For NONE, imm_o SHALL be 0.
REQ-007 use_imm_o SHALL be 1 for I, S, U and 0 for B, J, NONE and illegal.
REQ-008 The stage SHALL be one pipeline register with a valid/ready handshake and latency of exactly 1 cycle from capture to valid_o.
REQ-009 ready_o SHALL equal (!valid_o || ready_i) combinationally, and SHALL NOT depend on valid_i.
REQ-010 Capture SHALL occur when valid_i && ready_o && !flush_i; on capture all data outputs load the decode of inst_i/pc_i and valid_o<=1.
REQ-011 When valid_o && ready_i and no capture occurs, valid_o SHALL be 0 next cycle.
REQ-012 When valid_o && !ready_i, every output SHALL hold unchanged (no bubble, no overwrite).
REQ-013 Simultaneous drain and capture (valid_o, ready_i, valid_i all 1) SHALL replace the held result with no bubble cycle.
REQ-014 flush_i SHALL have priority over capture and hold: next cycle valid_o=0 and the instruction offered in the flush cycle is dropped.
REQ-015 Data outputs SHALL change only on capture or reset.
REQ-016 While valid_o=0, data output values SHALL be don't-care for consumers.

Reset
REQ-017 rst_i SHALL have priority over flush_i and capture.
REQ-018 On rst_i=1 at a clock edge, the next cycle SHALL show:
- valid_o=0
- pc_o=0, imm_o=0, imm_type_o=0
- rs1_o=rs2_o=rd_o=0
- use_imm_o=0, illegal_o=0
REQ-019 While rst_i=1, ready_o SHALL follow REQ-009 using the reset value of valid_o.
REQ-020 Reset mid-handshake SHALL discard the held instruction with no output.

Verification
REQ-021 inst_i=0xFFF00093 (addi x1,x0,-1), valid_i=1, ready_i=1 -> next cycle:
- valid_o=1, imm_o=0xFFFFFFFFFFFFFFFF
- imm_type_o=1, rd_o=1, use_imm_o=1
REQ-022 Back-to-back, one per cycle:
- 0xFE112E23 (sw) -> imm_o=0xFFFFFFFFFFFFFFFC, type 2, rs1_o=2, rs2_o=1
- 0xFFDFF06F (jal) -> imm_o=0xFFFFFFFFFFFFFFFC, type 5
- 0x800002B7 (lui x5) -> imm_o=0xFFFFFFFF80000000, type 4, rd_o=5
- required: no bubbles, results in order.
REQ-023 Hold valid_i=1 and ready_i=0 for 3 cycles -> ready_o=0 and outputs stable; then ready_i=1 -> the next instruction follows without loss or duplication.
REQ-024 inst_i=0x00000000 -> illegal_o=1, imm_o=0, use_imm_o=0; inst_i=0x002081B3 (add) -> type 0, imm_o=0, illegal_o=0.
REQ-025 flush_i=1 with valid_o=1 and valid_i=1 -> next cycle valid_o=0 and the offered instruction never appears at the output.
REQ-026 rst_i=1 while valid_o=1 and ready_i=0 -> next cycle all outputs at REQ-018 values and ready_o=1.

Source files
------------

// File: rtl/decode_stage_if.sv
// Bundles the fetch-side offer, the flush and the decoded result of the decode stage.
// The slave modport is the stage itself; the master modport is whatever surrounds it.
interface decode_stage_if;
  logic        [31:0] inst_i;
  logic        [63:0] pc_i;
  logic               valid_i;
  logic               ready_o;
  logic               flush_i;
  logic               valid_o;
  logic               ready_i;
  logic        [63:0] pc_o;
  logic signed [63:0] imm_o;
  logic        [2:0]  imm_type_o;
  logic        [4:0]  rs1_o;
  logic        [4:0]  rs2_o;
  logic        [4:0]  rd_o;
  logic               use_imm_o;
  logic               illegal_o;

  modport slave (
    input  inst_i, pc_i, valid_i, flush_i, ready_i,
    output ready_o, valid_o, pc_o, imm_o, imm_type_o, rs1_o, rs2_o, rd_o,
           use_imm_o, illegal_o
  );

  modport master (
    output inst_i, pc_i, valid_i, flush_i, ready_i,
    input  ready_o, valid_o, pc_o, imm_o, imm_type_o, rs1_o, rs2_o, rd_o,
           use_imm_o, illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// RV64I decode stage: classifies the opcode, builds the sign-extended immediate and
// holds the result in a single valid/ready pipeline register.
module decode_stage (
  input  logic          clk_i,
  input  logic          rst_i,
  decode_stage_if.slave dif
);
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  function automatic logic signed [63:0] imm_gen(input logic [31:0] inst,
                                                 input imm_type_e   typ);
    logic signed [63:0] imm;
    imm = '0;
    case (typ)
      IMM_I: imm = {{52{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J: imm = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  logic               valid_q, valid_d;
  logic        [63:0] pc_q;
  logic signed [63:0] imm_q, imm_d;
  imm_type_e          imm_type_q, imm_type_d;
  logic        [4:0]  rs1_q, rs2_q, rd_q;
  logic               use_imm_q, use_imm_d;
  logic               illegal_q, illegal_d;
  logic               ready;
  logic               capture;

  // Decode of the offered instruction
  always_comb begin
    imm_type_d = IMM_NONE;
    illegal_d  = 1'b0;
    // A full 7-bit match also rejects compressed encodings (inst[1:0] != 2'b11).
    case (dif.inst_i[6:0])
      7'b0110111, 7'b0010111: imm_type_d = IMM_U;
      7'b1101111:             imm_type_d = IMM_J;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b0011011, 7'b0001111, 7'b1110011: imm_type_d = IMM_I;
      7'b1100011:             imm_type_d = IMM_B;
      7'b0100011:             imm_type_d = IMM_S;
      7'b0110011, 7'b0111011: imm_type_d = IMM_NONE;
      default:                illegal_d  = 1'b1;
    endcase
    imm_d     = imm_gen(dif.inst_i, imm_type_d);
    use_imm_d = (imm_type_d == IMM_I) || (imm_type_d == IMM_S) || (imm_type_d == IMM_U);
  end

  // Handshake control
  assign ready   = !valid_q || dif.ready_i;
  assign capture = dif.valid_i && ready && !dif.flush_i;

  always_comb begin
    valid_d = valid_q;
    if (dif.flush_i)
      valid_d = 1'b0;
    else if (capture)
      valid_d = 1'b1;
    else if (valid_q && dif.ready_i)
      valid_d = 1'b0;
  end

  // Result register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      imm_type_q <= IMM_NONE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      use_imm_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        pc_q       <= dif.pc_i;
        imm_q      <= imm_d;
        imm_type_q <= imm_type_d;
        rs1_q      <= dif.inst_i[19:15];
        rs2_q      <= dif.inst_i[24:20];
        rd_q       <= dif.inst_i[11:7];
        use_imm_q  <= use_imm_d;
        illegal_q  <= illegal_d;
      end
    end
  end

  assign dif.ready_o    = ready;
  assign dif.valid_o    = valid_q;
  assign dif.pc_o       = pc_q;
  assign dif.imm_o      = imm_q;
  assign dif.imm_type_o = imm_type_q;
  assign dif.rs1_o      = rs1_q;
  assign dif.rs2_o      = rs2_q;
  assign dif.rd_o       = rd_q;
  assign dif.use_imm_o  = use_imm_q;
  assign dif.illegal_o  = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected decodes are queued on capture and
// compared against the held output every cycle until the result is consumed.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  decode_stage_if dif ();

  decode_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .dif   (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_imm;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode written from the RV64I tables
  function automatic exp_t model(input logic [31:0] in, input logic [63:0] pc);
    exp_t   e;
    longint v;
    e.pc  = pc;
    e.rs1 = in[19:15];
    e.rs2 = in[24:20];
    e.rd  = in[11:7];
    e.ill = 1'b0;
    case (in[6:0])
      7'h37, 7'h17: e.typ = 3'd4;
      7'h6F:        e.typ = 3'd5;
      7'h67, 7'h03, 7'h13, 7'h1B, 7'h0F, 7'h73: e.typ = 3'd1;
      7'h63:        e.typ = 3'd3;
      7'h23:        e.typ = 3'd2;
      7'h33, 7'h3B: e.typ = 3'd0;
      default: begin e.typ = 3'd0; e.ill = 1'b1; end
    endcase
    case (e.typ)
      3'd1: v = $signed(in[31:20]);
      3'd2: v = $signed({in[31:25], in[11:7]});
      3'd3: v = $signed({in[31], in[7], in[30:25], in[11:8], 1'b0});
      3'd4: v = $signed({in[31:12], 12'b0});
      3'd5: v = $signed({in[31], in[19:12], in[20], in[30:21], 1'b0});
      default: v = 0;
    endcase
    e.imm     = v;
    e.use_imm = (e.typ == 3'd1) || (e.typ == 3'd2) || (e.typ == 3'd4);
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    check_eq({tag, ".pc"},      dif.pc_o,              e.pc);
    check_eq({tag, ".imm"},     dif.imm_o,             e.imm);
    check_eq({tag, ".type"},    64'(dif.imm_type_o),   64'(e.typ));
    check_eq({tag, ".rs1"},     64'(dif.rs1_o),        64'(e.rs1));
    check_eq({tag, ".rs2"},     64'(dif.rs2_o),        64'(e.rs2));
    check_eq({tag, ".rd"},      64'(dif.rd_o),         64'(e.rd));
    check_eq({tag, ".use_imm"}, 64'(dif.use_imm_o),    64'(e.use_imm));
    check_eq({tag, ".illegal"}, 64'(dif.illegal_o),    64'(e.ill));
  endtask

  // One clock cycle: drive at negedge, check settled outputs, update scoreboard, advance.
  task automatic cycle(input string tag, input logic v, input logic [31:0] inst,
                       input logic [63:0] pc, input logic rdy, input logic fl,
                       input logic rs, input exp_t e);
    logic cap;
    dif.valid_i = v;
    dif.inst_i  = inst;
    dif.pc_i    = pc;
    dif.ready_i = rdy;
    dif.flush_i = fl;
    rst         = rs;
    #1;
    check_eq({tag, ".valid_o"}, 64'(dif.valid_o), 64'(sb_q.size() != 0));
    check_eq({tag, ".ready_o"}, 64'(dif.ready_o), 64'(!dif.valid_o || rdy));
    if (dif.valid_o && sb_q.size() != 0) cmp_out(tag, sb_q[0]);
    cap = v && dif.ready_o && !fl && !rs;
    if (sb_q.size() != 0 && (rdy || fl || rs)) void'(sb_q.pop_front());
    if (cap) sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                       input logic rdy);
    cycle(tag, 1'b1, inst, pc, rdy, 1'b0, 1'b0, model(inst, pc));
  endtask

  task automatic idle(input string tag, input logic rdy);
    cycle(tag, 1'b0, 32'h0, 64'h0, rdy, 1'b0, 1'b0, model(32'h0, 64'h0));
  endtask

  logic [6:0] opc_tab [12];
  exp_t       e;

  initial begin
    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h0F, 7'h73,
                7'h63, 7'h23, 7'h33};
    dif.valid_i = 1'b0; dif.inst_i = '0; dif.pc_i = '0;
    dif.ready_i = 1'b0; dif.flush_i = 1'b0; rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_eq("rst.valid_o", 64'(dif.valid_o), 64'd0);
    check_eq("rst.ready_o", 64'(dif.ready_o), 64'd1);
    e = '{pc: 64'd0, imm: 64'd0, typ: 3'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
          use_imm: 1'b0, ill: 1'b0};
    cmp_out("rst", e);
    rst = 1'b0;

    // addi x1,x0,-1
    e = model(32'hFFF00093, 64'h1000);
    e.imm = 64'hFFFFFFFFFFFFFFFF; e.typ = 3'd1; e.rd = 5'd1; e.use_imm = 1'b1;
    cycle("addi", 1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0, 1'b0, e);

    // back-to-back sw, jal, lui
    e = model(32'hFE112E23, 64'h1004);
    e.imm = 64'hFFFFFFFFFFFFFFFC; e.typ = 3'd2; e.rs1 = 5'd2; e.rs2 = 5'd1;
    cycle("sw", 1'b1, 32'hFE112E23, 64'h1004, 1'b1, 1'b0, 1'b0, e);
    e = model(32'hFFDFF06F, 64'h1008);
    e.imm = 64'hFFFFFFFFFFFFFFFC; e.typ = 3'd5; e.use_imm = 1'b0;
    cycle("jal", 1'b1, 32'hFFDFF06F, 64'h1008, 1'b1, 1'b0, 1'b0, e);
    e = model(32'h800002B7, 64'h100C);
    e.imm = 64'hFFFFFFFF80000000; e.typ = 3'd4; e.rd = 5'd5;
    cycle("lui", 1'b1, 32'h800002B7, 64'h100C, 1'b1, 1'b0, 1'b0, e);
    idle("drain", 1'b1);

    // stall: A captured, B offered for 3 stalled cycles, then released
    offer("stallA", 32'h00A00513, 64'h2000, 1'b0);
    for (int i = 0; i < 3; i++) offer("stallB", 32'h00B00593, 64'h2004, 1'b0);
    offer("relB", 32'h00B00593, 64'h2004, 1'b1);
    offer("nextC", 32'h00C00613, 64'h2008, 1'b1);
    idle("drain2", 1'b1);

    // illegal zero word and register-register add
    e = model(32'h0, 64'h3000);
    e.ill = 1'b1; e.imm = 64'd0; e.use_imm = 1'b0; e.typ = 3'd0;
    cycle("ill0", 1'b1, 32'h0, 64'h3000, 1'b1, 1'b0, 1'b0, e);
    e = model(32'h002081B3, 64'h3004);
    e.typ = 3'd0; e.imm = 64'd0; e.ill = 1'b0; e.use_imm = 1'b0;
    cycle("add", 1'b1, 32'h002081B3, 64'h3004, 1'b1, 1'b0, 1'b0, e);
    offer("cmpr", 32'h00004501, 64'h3008, 1'b1);
    idle("drain3", 1'b1);

    // randomized traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      logic [31:0] ins;
      logic        v, rdy, fl;
      r   = $urandom;
      ins = ($urandom_range(0, 9) == 0) ? $urandom : {r[31:7], opc_tab[$urandom_range(0, 11)]};
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 11) == 0);
      cycle("rand", v, ins, 64'h4000 + 64'(i * 4), rdy, fl, 1'b0, model(ins, 64'h4000 + 64'(i * 4)));
    end
    idle("drain4", 1'b1);

    // flush with a held result and a new offer
    offer("flA", 32'h00100093, 64'h5000, 1'b0);
    cycle("flush", 1'b1, 32'h00200113, 64'h5004, 1'b0, 1'b1, 1'b0, model(32'h00200113, 64'h5004));
    idle("postfl", 1'b1);
    idle("postfl2", 1'b1);

    // reset while holding a stalled result
    offer("rsA", 32'h00300193, 64'h6000, 1'b0);
    cycle("rsthold", 1'b1, 32'h00400213, 64'h6004, 1'b0, 1'b0, 1'b1, model(32'h00400213, 64'h6004));
    check_eq("rst2.ready_o", 64'(dif.ready_o), 64'd1);
    e = '{pc: 64'd0, imm: 64'd0, typ: 3'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
          use_imm: 1'b0, ill: 1'b0};
    cmp_out("rst2", e);
    idle("postrst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
